pwm_peripheral: RTL
===================

PWM_PERIPHERAL -- requirements
Module: pwm_peripheral

Interface
REQ-001 SHALL have parameter PRESCALE, default 13, clk cycles per PWM count step; legal range 1..255.
REQ-002 SHALL have port clk  input  1  system clock, all state on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-high (asserted when 1).
REQ-004 SHALL have port en_reg_out_7_0  input  8  per-pin output enable, pins 7..0.
REQ-005 SHALL have port en_reg_out_15_8  input  8  per-pin output enable, pins 15..8.
REQ-006 SHALL have port en_reg_pwm_7_0  input  8  per-pin PWM select, pins 7..0.
REQ-007 SHALL have port en_reg_pwm_15_8  input  8  per-pin PWM select, pins 15..8.
REQ-008 SHALL have port pwm_duty_cycle  input  8  requested duty, unsigned, 0x00 = 0%, 0xFF = 100%.
REQ-009 SHALL have port out  output  16  registered pin drive, bit i = pin i.
REQ-010 SHALL have port period_start  output  1  one-cycle pulse marking PWM period boundary.

Function
REQ-011 Prescaler pre_cnt SHALL count 0..PRESCALE-1 then wrap to 0; tick = (pre_cnt == PRESCALE-1).
REQ-012 8-bit pwm_cnt SHALL increment on each tick only, wrapping 255 -> 0 (period = 256*PRESCALE clk cycles).
REQ-013 duty_shadow SHALL load pwm_duty_cycle only on the cycle where tick && pwm_cnt == 255; otherwise hold.
REQ-014 pwm_level SHALL be 1 when duty_shadow == 0xFF, else (pwm_cnt < duty_shadow), unsigned 8-bit compare.
REQ-015 Each clk, out[i] SHALL register: 0 if enable bit i = 0; 1 if enable = 1 and PWM select = 0; pwm_level if both = 1.
REQ-016 Enable/select changes SHALL reach out one clk later, mid-period, without waiting for a boundary.
REQ-017 Duty changes SHALL take effect only from the next period boundary; mid-period writes never glitch the current period.
REQ-018 period_start SHALL register (tick && pwm_cnt == 255), i.e. high for exactly one clk each period, coincident with pwm_cnt showing 0.
REQ-019 Duty 0x00 SHALL give constant 0 on PWM pins; 0xFF constant 1; 0x01 SHALL give exactly PRESCALE high clk cycles per period.
REQ-020 PRESCALE = 1 SHALL give tick every cycle, period 256 clk.
REQ-021 Inputs SHALL be treated as synchronous to clk (upstream register block runs on the same clk); no synchronisers.

Reset
REQ-022 Asserting rst_n SHALL immediately clear pre_cnt, pwm_cnt, duty_shadow, out (0x0000) and period_start (0), independent of clk.
REQ-023 Reset asserted mid-period SHALL abort the period; after release counting SHALL restart from pre_cnt = 0, pwm_cnt = 0 with duty_shadow = 0.
REQ-024 After release, first period_start SHALL occur 256*PRESCALE clk cycles later, and the new duty SHALL apply from then.

Structure
REQ-025 Shared package pwm_pkg SHALL hold PWM_CNT_W = 8, DUTY_FULL = 8'hFF, NUM_PINS = 16, PRESCALE_DEFAULT = 13.
REQ-026 Prescaler SHALL be one sub-module pwm_prescaler (ports clk, rst_n, tick); counter, shadow, compare and output mux stay in pwm_peripheral.

Verification (PRESCALE = 13)
REQ-027 Reset mid-run with out = 0xFFFF -> out = 0x0000 and period_start = 0 before next clk edge; period_start next seen 3328 cycles after release.
REQ-028 en_out = 0xFFFF, en_pwm = 0x0000, duty = 0x80 -> out = 0xFFFF one clk after inputs settle, constant thereafter.
REQ-029 en_out = 0x0001, en_pwm = 0x0001, duty = 0x80 -> after first boundary, out[0] high 1664 / low 1664 cycles per 3328-cycle period; out[15:1] = 0.
REQ-030 en_out = en_pwm = 0x8000, duty 0x00 then 0xFF -> out[15] constant 0, then constant 1 from the following boundary with no low cycle.
REQ-031 duty 0x40 -> 0xC0 written mid-period -> current period keeps 832 high cycles; next period 2496 high cycles, change aligned to period_start.
REQ-032 en_pwm toggled mid-period on an enabled pin -> out switches between 1 and pwm_level exactly one clk later; pwm_cnt phase unaffected.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants, types and the duty compare for the PWM peripheral.
package pwm_pkg;

  localparam int unsigned PWM_CNT_W        = 8;
  localparam int unsigned NUM_PINS         = 16;
  localparam int unsigned PRESCALE_DEFAULT = 13;
  localparam int unsigned PRE_CNT_W        = 8;

  typedef logic [PWM_CNT_W-1:0] pwm_cnt_t;

  localparam pwm_cnt_t DUTY_FULL = 8'hFF;

  typedef struct packed {
    logic [NUM_PINS-1:0] en_out;
    logic [NUM_PINS-1:0] en_pwm;
  } pin_cfg_t;

  // Full-scale duty is forced high so 0xFF yields a gap-free 100% output.
  function automatic logic pwm_compare(input pwm_cnt_t cnt, input pwm_cnt_t duty);
    return (duty == DUTY_FULL) || (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Divides clk into one-cycle ticks, one every PRESCALE clk cycles.
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int unsigned PRESCALE = PRESCALE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam logic [PRE_CNT_W-1:0] PRE_LAST = PRE_CNT_W'(PRESCALE - 1);

  logic [PRE_CNT_W-1:0] r_pre_cnt;
  logic                 w_tick;

  assign w_tick = (r_pre_cnt == PRE_LAST);

  // rst_n is active-high despite its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_pre_cnt <= '0;
    end else if (w_tick) begin
      r_pre_cnt <= '0;
    end else begin
      r_pre_cnt <= r_pre_cnt + PRE_CNT_W'(1);
    end
  end

  assign tick = w_tick;

endmodule

// File: rtl/pwm_peripheral.sv
// 16-pin output block: each pin is off, static on, or driven by a shared
// 8-bit PWM whose duty is shadowed and only updated at period boundaries.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int unsigned PRESCALE = PRESCALE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam pwm_cnt_t CNT_LAST = '1;

  logic                w_tick;
  logic                w_period_end;
  logic                w_pwm_level;
  pin_cfg_t            w_cfg;
  logic [NUM_PINS-1:0] w_out_next;

  pwm_cnt_t            r_pwm_cnt;
  pwm_cnt_t            r_duty_shadow;
  logic [NUM_PINS-1:0] r_out;
  logic                r_period_start;

  pwm_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (w_tick)
  );

  assign w_cfg.en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign w_cfg.en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  assign w_period_end = w_tick && (r_pwm_cnt == CNT_LAST);
  assign w_pwm_level  = pwm_compare(r_pwm_cnt, r_duty_shadow);

  // Disabled -> 0, enabled static -> 1, enabled PWM -> shared level.
  assign w_out_next = w_cfg.en_out & (~w_cfg.en_pwm | {NUM_PINS{w_pwm_level}});

  // Period counter and duty shadow; a duty write only lands on the wrap tick.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_pwm_cnt     <= '0;
      r_duty_shadow <= '0;
    end else begin
      if (w_tick) begin
        r_pwm_cnt <= r_pwm_cnt + PWM_CNT_W'(1);
      end
      if (w_period_end) begin
        r_duty_shadow <= pwm_duty_cycle;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_out          <= '0;
      r_period_start <= 1'b0;
    end else begin
      r_out          <= w_out_next;
      r_period_start <= w_period_end;
    end
  end

  assign out          = r_out;
  assign period_start = r_period_start;

endmodule
